// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port (link, load, ALU).
// Byte/halfword loads are sequenced as read-modify-write through the read port.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lnk_valid,
  input  logic [ADDR_W-1:0] lnk_addr,
  input  logic [DATA_W-1:0] lnk_data,
  output logic              lnk_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [1:0]        ld_size,
  output logic              ld_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_re,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(STARVE_LIM + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIM);

  typedef enum logic [1:0] {StIdle, StRd, StMrg} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
  logic [15:0]       rmw_data_q, rmw_data_d;
  logic              rmw_byte_q, rmw_byte_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              gnt_lnk, gnt_ld, gnt_alu;
  logic              alu_boost;
  logic              ld_partial;
  logic [DATA_W-1:0] keep_mask;
  logic [DATA_W-1:0] data_ext;
  logic [DATA_W-1:0] merged;

  // A starved ALU request pre-empts the fixed lnk > ld > alu order for one grant.
  assign alu_boost  = alu_valid && (starve_q == CntMax);
  assign ld_partial = (ld_size == 2'b01) || (ld_size == 2'b10);

  always_comb begin
    gnt_lnk = 1'b0;
    gnt_ld  = 1'b0;
    gnt_alu = 1'b0;
    if (state_q == StIdle) begin
      if (alu_boost) begin
        gnt_alu = 1'b1;
      end else if (lnk_valid) begin
        gnt_lnk = 1'b1;
      end else if (ld_valid) begin
        gnt_ld = 1'b1;
      end else if (alu_valid) begin
        gnt_alu = 1'b1;
      end
    end
  end

  assign lnk_ready = gnt_lnk;
  assign ld_ready  = gnt_ld;
  assign alu_ready = gnt_alu;

  // Upper bits come from the register's current contents, low lane from the load.
  assign keep_mask = rmw_byte_q ? {{(DATA_W-8){1'b1}}, 8'h00} : {{(DATA_W-16){1'b1}}, 16'h0000};
  assign data_ext  = {{(DATA_W-16){1'b0}}, rmw_data_q};
  assign merged    = (rf_rdata & keep_mask) | (data_ext & ~keep_mask);

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    rmw_addr_d = rmw_addr_q;
    rmw_data_d = rmw_data_q;
    rmw_byte_d = rmw_byte_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_alu || !alu_valid) begin
          starve_d = '0;
        end else if (starve_q != CntMax) begin
          starve_d = starve_q + CntW'(1);
        end
        if (gnt_lnk) begin
          we_d    = |lnk_addr;
          waddr_d = lnk_addr;
          wdata_d = lnk_data;
        end else if (gnt_ld && ld_partial) begin
          state_d    = StRd;
          rmw_addr_d = ld_addr;
          rmw_data_d = ld_data[15:0];
          rmw_byte_d = (ld_size == 2'b10);
        end else if (gnt_ld) begin
          we_d    = |ld_addr;
          waddr_d = ld_addr;
          wdata_d = ld_data;
        end else if (gnt_alu) begin
          we_d    = |alu_addr;
          waddr_d = alu_addr;
          wdata_d = alu_data;
        end
      end
      StRd: begin
        state_d = StMrg;
        we_d    = |rmw_addr_q;
        waddr_d = rmw_addr_q;
        wdata_d = merged;
      end
      StMrg: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      starve_q   <= '0;
      rmw_addr_q <= '0;
      rmw_data_q <= '0;
      rmw_byte_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rmw_addr_q <= rmw_addr_d;
      rmw_data_q <= rmw_data_d;
      rmw_byte_q <= rmw_byte_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign rf_re    = (state_q == StRd);
  assign rf_raddr = rf_re ? rmw_addr_q : '0;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then randomized traffic, each cycle checked
// against a transaction-level model of grants, RMW timing and register-file contents.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          lnk_valid = 1'b0, ld_valid = 1'b0, alu_valid = 1'b0;
  logic [AW-1:0] lnk_addr = '0, ld_addr = '0, alu_addr = '0;
  logic [DW-1:0] lnk_data = '0, ld_data = '0, alu_data = '0;
  logic [1:0]    ld_size = 2'b00;
  logic          lnk_ready, ld_ready, alu_ready;
  logic          rf_we, rf_re, busy;
  logic [AW-1:0] rf_waddr, rf_raddr;
  logic [DW-1:0] rf_wdata, rf_rdata;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .lnk_valid(lnk_valid), .lnk_addr(lnk_addr), .lnk_data(lnk_data), .lnk_ready(lnk_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_size(ld_size),
    .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // Bench-side register file driven by the DUT write port.
  logic [31:0] regs [32];
  logic        init_done = 1'b0;
  assign rf_rdata = regs[rf_raddr];
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
      init_done <= 1'b1;
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  typedef enum int {GNone, GLnk, GLd, GAlu} gnt_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mregs [32];
  int          m_left;      // RMW cycles still to run: 2 = read cycle now, 1 = merge cycle now
  int          m_starve;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_byte;
  logic        p_we;        // write expected on the port in the coming cycle
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  gnt_t        last_g = GNone;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_cycle();
    gnt_t        g;
    logic        n_we;
    logic [4:0]  n_addr;
    logic [31:0] n_data, mask;
    chk("rf_we", rf_we, p_we);
    if (p_we) begin
      chk("rf_waddr", rf_waddr, p_addr);
      chk("rf_wdata", rf_wdata, p_data);
      mregs[p_addr] = p_data;
    end
    chk("busy", busy, m_left != 0);
    chk("rf_re", rf_re, m_left == 2);
    chk("rf_raddr", rf_raddr, (m_left == 2) ? m_addr : 5'd0);
    g = GNone;
    if (m_left == 0) begin
      if (alu_valid && m_starve == LIM) g = GAlu;
      else if (lnk_valid) g = GLnk;
      else if (ld_valid) g = GLd;
      else if (alu_valid) g = GAlu;
    end
    chk("lnk_ready", lnk_ready, g == GLnk);
    chk("ld_ready", ld_ready, g == GLd);
    chk("alu_ready", alu_ready, g == GAlu);
    n_we = 1'b0;
    n_addr = p_addr;
    n_data = p_data;
    if (m_left == 2) begin
      mask   = m_byte ? 32'h0000_00FF : 32'h0000_FFFF;
      n_data = (mregs[m_addr] & ~mask) | (m_data & mask);
      n_addr = m_addr;
      n_we   = (m_addr != 0);
      m_left = 1;
    end else if (m_left == 1) begin
      m_left = 0;
    end else begin
      if (alu_valid && g != GAlu) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      else m_starve = 0;
      case (g)
        GLnk: begin n_we = (lnk_addr != 0); n_addr = lnk_addr; n_data = lnk_data; end
        GLd: begin
          if (ld_size == 2'b01 || ld_size == 2'b10) begin
            m_left = 2; m_addr = ld_addr; m_data = ld_data; m_byte = (ld_size == 2'b10);
          end else begin
            n_we = (ld_addr != 0); n_addr = ld_addr; n_data = ld_data;
          end
        end
        GAlu: begin n_we = (alu_addr != 0); n_addr = alu_addr; n_data = alu_data; end
        default: ;
      endcase
    end
    p_we = n_we;
    p_addr = n_addr;
    p_data = n_data;
    last_g = g;
  endtask

  // One clock: check at the falling edge, then retire whatever was accepted.
  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    if (last_g == GLnk) lnk_valid = 1'b0;
    if (last_g == GLd) ld_valid = 1'b0;
    if (last_g == GAlu) alu_valid = 1'b0;
  endtask

  task automatic do_reset();
    lnk_valid = 1'b0;
    ld_valid  = 1'b0;
    alu_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_re", rf_re, 0);
    chk("rst_raddr", rf_raddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_readys", {lnk_ready, ld_ready, alu_ready}, 0);
    m_left = 0;
    m_starve = 0;
    p_we = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] saved;

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = init_val(i);
    m_left = 0; m_starve = 0; p_we = 1'b0; p_addr = '0; p_data = '0;
    m_addr = '0; m_data = '0; m_byte = 1'b0;
    #2;
    do_reset();

    // Three simultaneous word requests drain in priority order.
    lnk_valid = 1; lnk_addr = 31; lnk_data = 32'hAAAA_0031;
    ld_valid = 1; ld_addr = 5; ld_data = 32'hBBBB_0005; ld_size = 2'b00;
    alu_valid = 1; alu_addr = 6; alu_data = 32'hCCCC_0006;
    step(); chk("t2_w0", rf_waddr, 31);
    step(); chk("t2_w1", rf_waddr, 5);
    step(); chk("t2_w2", rf_waddr, 6);
    step();

    // Byte load merges into the existing register value.
    alu_valid = 1; alu_addr = 8; alu_data = 32'h1234_5678;
    step(); step();
    ld_valid = 1; ld_addr = 8; ld_data = 32'h0000_00AB; ld_size = 2'b10;
    step();
    chk("t3_rd_re", rf_re, 1);
    chk("t3_rd_raddr", rf_raddr, 8);
    step(); step();
    chk("t3_wdata", rf_wdata, 32'h1234_56AB);
    chk("t3_r8", regs[8], 32'h1234_56AB);

    // Halfword load with an ALU request waiting out the RMW.
    lnk_valid = 1; lnk_addr = 9; lnk_data = 32'hCAFE_0000;
    step(); step();
    ld_valid = 1; ld_addr = 9; ld_data = 32'h0000_BEEF; ld_size = 2'b01;
    alu_valid = 1; alu_addr = 10; alu_data = 32'h0000_0077;
    step(); step(); step();
    chk("t4_r9", regs[9], 32'hCAFE_BEEF);
    chk("t4_alu_waiting", alu_valid, 1);
    step();
    chk("t4_alu_wr", rf_waddr, 10);
    step();

    // Link held high starves the ALU until the boost grant.
    lnk_valid = 1; lnk_addr = 12; lnk_data = 32'h0000_1212;
    alu_valid = 1; alu_addr = 11; alu_data = 32'h0000_0055;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t5_waddr%0d", i), rf_waddr, (i == 4) ? 11 : 12);
      lnk_valid = 1;
    end
    lnk_valid = 0;
    step();

    // Address 0 writes are suppressed; reset during the read cycle aborts the RMW.
    alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFF_FFFF;
    step();
    chk("t6_we_addr0", rf_we, 0);
    saved = regs[3];
    ld_valid = 1; ld_addr = 3; ld_data = 32'h0000_0011; ld_size = 2'b10;
    step();
    chk("t6_in_rd", busy, 1);
    do_reset();
    step(); step();
    chk("t6_r3_kept", regs[3], saved);

    // Randomized traffic; requests stay stable until accepted.
    for (int c = 0; c < 1500; c++) begin
      if (!lnk_valid && $urandom_range(0, 99) < 30) begin
        lnk_valid = 1; lnk_addr = 5'($urandom_range(0, 7)); lnk_data = $urandom;
      end
      if (!ld_valid && $urandom_range(0, 99) < 35) begin
        ld_valid = 1; ld_addr = 5'($urandom_range(0, 7)); ld_data = $urandom;
        ld_size = 2'($urandom_range(0, 3));
      end
      if (!alu_valid && $urandom_range(0, 99) < 50) begin
        alu_valid = 1; alu_addr = 5'($urandom_range(0, 7)); alu_data = $urandom;
      end
      step();
    end
    lnk_valid = 0; ld_valid = 0; alu_valid = 0;
    step(); step(); step();
    for (int i = 0; i < 8; i++) chk($sformatf("final_r%0d", i), regs[i], mregs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
